// File: rtl/pic_command_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pic_command_sequencer_pkg                                    |
// | Description : Shared types and bit positions for the 8259 command          |
// |               sequencer: FSM state encoding, ICW/OCW field positions and   |
// |               the strobe-vector bit order used by the commit detector.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pic_command_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  // Strobe vector order: {write_icw1, write_a0, write_ocw2, write_ocw3}
  localparam int STRB_ICW1 = 3;
  localparam int STRB_A0   = 2;
  localparam int STRB_OCW2 = 1;
  localparam int STRB_OCW3 = 0;

  // ICW1 fields
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;

  // ICW4 fields
  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  // OCW2 fields
  localparam int OCW2_EOI = 5;
  localparam int OCW2_SL  = 6;
  localparam int OCW2_R   = 7;

  // OCW3 fields
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

endpackage : pic_command_sequencer_pkg
`default_nettype wire

// File: rtl/pic_command_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pic_command_sequencer_if                                     |
// | Description : Write-side bus from Bus_Control_Logic into the sequencer.    |
// |   internal_data_bus [7:0] latched write data                               |
// |   write_icw1              ICW1 write strobe (level, whole write)           |
// |   write_a0                ICW2..4 / OCW1 write strobe                      |
// |   write_ocw2, write_ocw3  OCW2 / OCW3 write strobes                        |
// |   master = bus control side (drives), slave = sequencer side               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pic_command_sequencer_if;
  logic [7:0] internal_data_bus;
  logic       write_icw1;
  logic       write_a0;
  logic       write_ocw2;
  logic       write_ocw3;

  modport master (
    output internal_data_bus, write_icw1, write_a0, write_ocw2, write_ocw3
  );

  modport slave (
    input  internal_data_bus, write_icw1, write_a0, write_ocw2, write_ocw3
  );
endinterface : pic_command_sequencer_if
`default_nettype wire

// File: rtl/pic_command_sequencer_commit_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pic_write_commit_detect                                      |
// | Description : Registers the strobe vector every cycle and flags a commit   |
// |               on the trailing edge of a write (registered strobes nonzero, |
// |               live strobes all zero).                                      |
// |   clk, rst_n         clock / async active-low reset                        |
// |   strb [3:0]         live strobes {icw1, a0, ocw2, ocw3}                   |
// |   commit             1 in the trailing-edge cycle                          |
// |   commit_type [3:0]  strobe vector of the write being committed, else 0    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pic_write_commit_detect (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [3:0] strb,
  output logic            commit,
  output logic [3:0]      commit_type
);

  logic [3:0] strb_q;

  // Clearing strb_q on reset guarantees a write cut short by reset never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q <= 4'b0000;
    end else begin
      strb_q <= strb;
    end
  end

  assign commit      = (|strb_q) && (strb == 4'b0000);
  assign commit_type = commit ? strb_q : 4'b0000;

endmodule : pic_write_commit_detect
`default_nettype wire

// File: rtl/pic_command_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pic_command_sequencer                                        |
// | Description : Walks ICW1->ICW2->[ICW3]->[ICW4], then routes A0 writes to   |
// |               OCW1 and OCW2/OCW3 writes to command pulses and mode bits.   |
// |   clk, rst_n                   clock / async active-low reset              |
// |   bus (slave)                  write data and strobes                      |
// |   init_done                    1 when initialisation is complete           |
// |   level_or_edge_n, single_n_cascade   ICW1 LTIM / SNGL                     |
// |   interrupt_vector [4:0]       ICW2 D7:D3                                  |
// |   cascade_config [7:0]         ICW3                                        |
// |   upm,aeoi,buf_mode,buf_master,sfnm   ICW4 fields                          |
// |   interrupt_mask [7:0]         OCW1                                        |
// |   auto_rotate_mode             rotate-in-AEOI flag                         |
// |   eoi_nonspecific, eoi_specific, eoi_rotate, set_priority  OCW2 pulses     |
// |   cmd_level [2:0]              OCW2 L2:L0                                  |
// |   read_isr_n_irr, special_mask_mode   OCW3 state                           |
// |   poll_pulse                   OCW3 poll command pulse                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pic_command_sequencer
  import pic_command_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pic_command_sequencer_if.slave bus,
  output logic                 init_done,
  output logic                 level_or_edge_n,
  output logic                 single_n_cascade,
  output logic [4:0]           interrupt_vector,
  output logic [7:0]           cascade_config,
  output logic                 upm,
  output logic                 aeoi,
  output logic                 buf_mode,
  output logic                 buf_master,
  output logic                 sfnm,
  output logic [7:0]           interrupt_mask,
  output logic                 auto_rotate_mode,
  output logic                 eoi_nonspecific,
  output logic                 eoi_specific,
  output logic                 eoi_rotate,
  output logic                 set_priority,
  output logic [2:0]           cmd_level,
  output logic                 read_isr_n_irr,
  output logic                 special_mask_mode,
  output logic                 poll_pulse
);

  logic       commit;
  logic [3:0] commit_type;
  logic [7:0] data;
  logic       ic4;
  pic_state_e state;

  assign data = bus.internal_data_bus;

  pic_write_commit_detect u_commit_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .strb        ({bus.write_icw1, bus.write_a0, bus.write_ocw2, bus.write_ocw3}),
    .commit      (commit),
    .commit_type (commit_type)
  );

  // state is a register, so this output is glitch-free and lags the commit by one clock.
  assign init_done = (state == ST_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_UNINIT;
      ic4               <= 1'b0;
      level_or_edge_n   <= 1'b0;
      single_n_cascade  <= 1'b0;
      interrupt_vector  <= 5'd0;
      cascade_config    <= 8'h00;
      upm               <= 1'b0;
      aeoi              <= 1'b0;
      buf_mode          <= 1'b0;
      buf_master        <= 1'b0;
      sfnm              <= 1'b0;
      interrupt_mask    <= RESET_MASK;
      auto_rotate_mode  <= 1'b0;
      eoi_nonspecific   <= 1'b0;
      eoi_specific      <= 1'b0;
      eoi_rotate        <= 1'b0;
      set_priority      <= 1'b0;
      cmd_level         <= 3'd0;
      read_isr_n_irr    <= 1'b0;
      special_mask_mode <= 1'b0;
      poll_pulse        <= 1'b0;
    end else begin
      // Command pulses are single-cycle by default.
      eoi_nonspecific <= 1'b0;
      eoi_specific    <= 1'b0;
      eoi_rotate      <= 1'b0;
      set_priority    <= 1'b0;
      poll_pulse      <= 1'b0;

      if (commit_type[STRB_ICW1]) begin
        // ICW1 restarts initialisation from any state.
        level_or_edge_n   <= data[ICW1_LTIM];
        single_n_cascade  <= data[ICW1_SNGL];
        ic4               <= data[ICW1_IC4];
        upm               <= 1'b0;
        aeoi              <= 1'b0;
        buf_mode          <= 1'b0;
        buf_master        <= 1'b0;
        sfnm              <= 1'b0;
        interrupt_mask    <= RESET_MASK;
        auto_rotate_mode  <= 1'b0;
        special_mask_mode <= 1'b0;
        read_isr_n_irr    <= 1'b0;
        state             <= ST_WAIT_ICW2;
      end else if (commit_type[STRB_A0]) begin
        case (state)
          ST_WAIT_ICW2: begin
            interrupt_vector <= data[7:3];
            if (!single_n_cascade) state <= ST_WAIT_ICW3;
            else if (ic4)          state <= ST_WAIT_ICW4;
            else                   state <= ST_READY;
          end
          ST_WAIT_ICW3: begin
            cascade_config <= data;
            state          <= ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: begin
            upm        <= data[ICW4_UPM];
            aeoi       <= data[ICW4_AEOI];
            buf_master <= data[ICW4_MS];
            buf_mode   <= data[ICW4_BUF];
            sfnm       <= data[ICW4_SFNM];
            state      <= ST_READY;
          end
          ST_READY: interrupt_mask <= data;
          default: ;  // UNINIT: A0 writes are ignored
        endcase
      end else if (commit_type[STRB_OCW2] && (state == ST_READY)) begin
        cmd_level <= data[2:0];
        case ({data[OCW2_R], data[OCW2_SL], data[OCW2_EOI]})
          3'b001: eoi_nonspecific <= 1'b1;
          3'b101: begin
            eoi_nonspecific <= 1'b1;
            eoi_rotate      <= 1'b1;
          end
          3'b011, 3'b111: begin
            eoi_specific <= 1'b1;
            eoi_rotate   <= data[OCW2_R];
          end
          3'b110: set_priority     <= 1'b1;
          3'b100: auto_rotate_mode <= 1'b1;
          3'b000: auto_rotate_mode <= 1'b0;
          default: ;  // 010: no operation
        endcase
      end else if (commit_type[STRB_OCW3] && (state == ST_READY)) begin
        if (data[OCW3_RR])   read_isr_n_irr    <= data[OCW3_RIS];
        if (data[OCW3_ESMM]) special_mask_mode <= data[OCW3_SMM];
        if (data[OCW3_P])    poll_pulse        <= 1'b1;
      end
    end
  end

endmodule : pic_command_sequencer
`default_nettype wire

// File: tb/tb_pic_command_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pic_command_sequencer                                     |
// | Description : Self-checking bench for pic_command_sequencer. Each write    |
// |               updates a behavioural model and queues the expected output   |
// |               snapshot for the commit cycle and the cycle after; a monitor |
// |               pops and compares snapshots as they fall due.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pic_command_sequencer;

  localparam logic [7:0] RM = 8'h5A;
  localparam int K_ICW1 = 0;
  localparam int K_A0   = 1;
  localparam int K_OCW2 = 2;
  localparam int K_OCW3 = 3;

  localparam int M_UNINIT = 0;
  localparam int M_W2     = 1;
  localparam int M_W3     = 2;
  localparam int M_W4     = 3;
  localparam int M_READY  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_command_sequencer_if bus ();

  logic       init_done, level_or_edge_n, single_n_cascade;
  logic [4:0] interrupt_vector;
  logic [7:0] cascade_config, interrupt_mask;
  logic       upm, aeoi, buf_mode, buf_master, sfnm, auto_rotate_mode;
  logic       eoi_nonspecific, eoi_specific, eoi_rotate, set_priority, poll_pulse;
  logic [2:0] cmd_level;
  logic       read_isr_n_irr, special_mask_mode;

  pic_command_sequencer #(.RESET_MASK(RM)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .init_done         (init_done),
    .level_or_edge_n   (level_or_edge_n),
    .single_n_cascade  (single_n_cascade),
    .interrupt_vector  (interrupt_vector),
    .cascade_config    (cascade_config),
    .upm               (upm),
    .aeoi              (aeoi),
    .buf_mode          (buf_mode),
    .buf_master        (buf_master),
    .sfnm              (sfnm),
    .interrupt_mask    (interrupt_mask),
    .auto_rotate_mode  (auto_rotate_mode),
    .eoi_nonspecific   (eoi_nonspecific),
    .eoi_specific      (eoi_specific),
    .eoi_rotate        (eoi_rotate),
    .set_priority      (set_priority),
    .cmd_level         (cmd_level),
    .read_isr_n_irr    (read_isr_n_irr),
    .special_mask_mode (special_mask_mode),
    .poll_pulse        (poll_pulse)
  );

  typedef struct {
    int         due;
    logic       init_done;
    logic [1:0] icw1;     // {ltim, sngl}
    logic [4:0] vector;
    logic [7:0] cascade;
    logic [4:0] icw4;     // {sfnm, buf_mode, buf_master, aeoi, upm}
    logic [7:0] mask;
    logic       arm;
    logic [1:0] ocw3;     // {ris, smm}
    logic [2:0] lvl;
    logic [4:0] pulses;   // {nonspec, spec, rotate, set_pri, poll}
  } snap_t;

  snap_t sbq[$];
  snap_t m;
  int    mst;
  logic  m_ic4;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_reset();
    m.init_done = 1'b0; m.icw1 = 2'b00; m.vector = 5'd0; m.cascade = 8'h00;
    m.icw4 = 5'd0; m.mask = RM; m.arm = 1'b0; m.ocw3 = 2'b00; m.lvl = 3'd0;
    m.pulses = 5'd0; mst = M_UNINIT; m_ic4 = 1'b0;
  endfunction

  function automatic void model_apply(input int kind, input logic [7:0] d);
    logic r, sl, eoi;
    r = d[7]; sl = d[6]; eoi = d[5];
    if (kind == K_ICW1) begin
      m.icw1 = {d[3], d[1]}; m_ic4 = d[0]; m.icw4 = 5'd0; m.mask = RM;
      m.arm = 1'b0; m.ocw3 = 2'b00; mst = M_W2;
    end else if (kind == K_A0) begin
      if (mst == M_W2) begin
        m.vector = d[7:3];
        mst = (m.icw1[0] == 1'b0) ? M_W3 : (m_ic4 ? M_W4 : M_READY);
      end else if (mst == M_W3) begin
        m.cascade = d;
        mst = m_ic4 ? M_W4 : M_READY;
      end else if (mst == M_W4) begin
        m.icw4 = {d[4], d[3], d[2], d[1], d[0]};
        mst = M_READY;
      end else if (mst == M_READY) begin
        m.mask = d;
      end
    end else if (kind == K_OCW2 && mst == M_READY) begin
      m.lvl = d[2:0];
      if (eoi && !sl) m.pulses = {1'b1, 1'b0, r, 2'b00};
      if (eoi && sl)  m.pulses = {1'b0, 1'b1, r, 2'b00};
      if (!eoi && sl && r) m.pulses = 5'b00010;
      if (!eoi && !sl) m.arm = r;
    end else if (kind == K_OCW3 && mst == M_READY) begin
      if (d[1]) m.ocw3[1] = d[0];
      if (d[6]) m.ocw3[0] = d[5];
      if (d[2]) m.pulses = 5'b00001;
    end
  endfunction

  function automatic void push(input int due);
    snap_t s;
    s = m;
    s.due = due;
    s.init_done = (mst == M_READY);
    sbq.push_back(s);
  endfunction

  // Compare each queued snapshot at the negedge of the cycle it falls due.
  always @(negedge clk) begin
    snap_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check("init_done", 32'(init_done), 32'(e.init_done));
      check("icw1",      32'({level_or_edge_n, single_n_cascade}), 32'(e.icw1));
      check("vector",    32'(interrupt_vector), 32'(e.vector));
      check("cascade",   32'(cascade_config), 32'(e.cascade));
      check("icw4",      32'({sfnm, buf_mode, buf_master, aeoi, upm}), 32'(e.icw4));
      check("mask",      32'(interrupt_mask), 32'(e.mask));
      check("auto_rot",  32'(auto_rotate_mode), 32'(e.arm));
      check("ocw3",      32'({read_isr_n_irr, special_mask_mode}), 32'(e.ocw3));
      check("cmd_level", 32'(cmd_level), 32'(e.lvl));
      check("pulses",    32'({eoi_nonspecific, eoi_specific, eoi_rotate, set_priority, poll_pulse}),
                         32'(e.pulses));
    end
  end

  task automatic set_strobes(input int kind, input logic v);
    bus.write_icw1 = (kind == K_ICW1) ? v : 1'b0;
    bus.write_a0   = (kind == K_A0)   ? v : 1'b0;
    bus.write_ocw2 = (kind == K_OCW2) ? v : 1'b0;
    bus.write_ocw3 = (kind == K_OCW3) ? v : 1'b0;
  endtask

  // Two-clock write; results due one clock after the trailing-edge commit,
  // plus a follow-up snapshot with all pulses back at 0.
  task automatic wr(input int kind, input logic [7:0] d);
    @(negedge clk);
    bus.internal_data_bus = d;
    set_strobes(kind, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_strobes(kind, 1'b0);
    model_apply(kind, d);
    push(cyc + 1);
    m.pulses = 5'd0;
    push(cyc + 2);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  initial begin
    bus.internal_data_bus = 8'h00;
    set_strobes(K_ICW1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    push(cyc + 1);                 // reset state while rst_n is low
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    wr(K_A0,   8'hFF);             // before ICW1: ignored
    wr(K_OCW2, 8'h20);             // not ready: ignored
    wr(K_ICW1, 8'h13);             // SNGL, IC4
    wr(K_OCW2, 8'h63);             // mid-init: ignored
    wr(K_A0,   8'h48);             // vector 9
    wr(K_A0,   8'h03);             // upm, aeoi -> READY

    wr(K_ICW1, 8'h11);
    wr(K_A0,   8'h20);
    wr(K_ICW1, 8'h13);             // restart mid-init
    wr(K_ICW1, 8'h11);             // cascade, IC4
    wr(K_A0,   8'h20);
    wr(K_A0,   8'h04);             // ICW3
    wr(K_A0,   8'h01);             // ICW4
    wr(K_A0,   8'hA5);             // OCW1

    wr(K_OCW2, 8'h63);             // specific EOI, level 3
    wr(K_OCW2, 8'hC5);             // set priority, level 5
    wr(K_OCW2, 8'h80);             // rotate in AEOI on
    wr(K_OCW2, 8'h20);             // non-specific EOI
    wr(K_OCW2, 8'hA0);             // rotate on non-specific EOI
    wr(K_OCW2, 8'hE2);             // rotate on specific EOI
    wr(K_OCW2, 8'h00);             // rotate in AEOI off
    wr(K_OCW2, 8'h80);
    wr(K_OCW2, 8'h47);             // no-op
    wr(K_OCW3, 8'h0B);             // read ISR
    wr(K_OCW3, 8'h68);             // special mask on
    wr(K_OCW3, 8'h0C);             // poll
    wr(K_OCW3, 8'h0A);             // read IRR
    wr(K_OCW3, 8'h48);             // special mask off

    // Reset in the middle of an ICW1 write: no commit after release.
    @(negedge clk);
    bus.internal_data_bus = 8'h1B;
    set_strobes(K_ICW1, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #2 set_strobes(K_ICW1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push(cyc + 1);
    push(cyc + 2);
    repeat (4) @(negedge clk);

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pic_command_sequencer
`default_nettype wire
